// File: rtl/count_limit_checker.sv
// Monitor for a saturating 0..LIMIT up-counter: climb tracking, completion handshake, sticky error.
// Optional: define COUNT_LIMIT_ERR_CLR_EN to add err_clr for leaving ERR without reset.
module count_limit_checker #(
    parameter int W     = 3,
    parameter int LIMIT = 3,
    parameter int SW    = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [W-1:0]  cnt_in,
    input  logic          cnt_vld,
`ifdef COUNT_LIMIT_ERR_CLR_EN
    input  logic          err_clr,
`endif
    input  logic          done_rdy,
    output logic          done_vld,
    output logic [SW-1:0] done_samples,
    output logic          done_ovr,
    output logic          err,
    output logic [W-1:0]  err_val,
    output logic [1:0]    state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    localparam logic [W-1:0]  LIM  = W'(LIMIT);
    localparam logic [SW-1:0] SMAX = '1;

    logic [1:0]    state_nxt;
    logic [SW-1:0] scnt;
    logic [SW-1:0] scnt_nxt;
    logic [SW-1:0] scnt_inc;
    logic [SW-1:0] comp_cnt;
    logic [W-1:0]  last;
    logic [W-1:0]  last_nxt;
    logic [W-1:0]  err_val_nxt;
    logic          err_nxt;
    logic          comp;
    logic          clr;

`ifdef COUNT_LIMIT_ERR_CLR_EN
    assign clr = err_clr;
`else
    assign clr = 1'b0;
`endif

    always_comb begin
        scnt_inc = (scnt == SMAX) ? scnt : scnt + SW'(1);
    end

    always_comb begin
        state_nxt   = state;
        scnt_nxt    = scnt;
        last_nxt    = last;
        err_nxt     = err;
        err_val_nxt = err_val;
        comp        = 1'b0;
        comp_cnt    = '0;
        if (state == ERR) begin
            if (clr) begin
                state_nxt   = IDLE;
                err_nxt     = 1'b0;
                err_val_nxt = '0;
                scnt_nxt    = '0;
                last_nxt    = '0;
            end
        end else if (cnt_vld) begin
            if (cnt_in > LIM) begin
                state_nxt   = ERR;
                err_nxt     = 1'b1;
                err_val_nxt = cnt_in;
            end else begin
                case (state)
                    IDLE: begin
                        // Checked first so LIMIT=1 goes straight to HOLD
                        if (cnt_in == LIM) begin
                            state_nxt = HOLD;
                            comp      = 1'b1;
                            comp_cnt  = SW'(1);
                        end else if (cnt_in != '0) begin
                            state_nxt = RUN;
                            scnt_nxt  = SW'(1);
                            last_nxt  = cnt_in;
                        end
                    end
                    RUN: begin
                        if (cnt_in != '0 && cnt_in < last) begin
                            state_nxt   = ERR;
                            err_nxt     = 1'b1;
                            err_val_nxt = cnt_in;
                        end else if (cnt_in == '0) begin
                            state_nxt = IDLE;
                            scnt_nxt  = '0;
                            last_nxt  = '0;
                        end else if (cnt_in == LIM) begin
                            state_nxt = HOLD;
                            comp      = 1'b1;
                            comp_cnt  = scnt_inc;
                        end else begin
                            scnt_nxt = scnt_inc;
                            last_nxt = cnt_in;
                        end
                    end
                    HOLD: begin
                        if (cnt_in == '0) begin
                            state_nxt = IDLE;
                            scnt_nxt  = '0;
                            last_nxt  = '0;
                        end else if (cnt_in != LIM) begin
                            state_nxt   = ERR;
                            err_nxt     = 1'b1;
                            err_val_nxt = cnt_in;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            scnt         <= '0;
            last         <= '0;
            err          <= 1'b0;
            err_val      <= '0;
            done_vld     <= 1'b0;
            done_samples <= '0;
            done_ovr     <= 1'b0;
        end else begin
            state   <= state_nxt;
            scnt    <= scnt_nxt;
            last    <= last_nxt;
            err     <= err_nxt;
            err_val <= err_val_nxt;
            // A completion only lands if the slot is empty or draining now
            if (comp) begin
                if (!done_vld || done_rdy) begin
                    done_vld     <= 1'b1;
                    done_samples <= comp_cnt;
                end else begin
                    done_ovr <= 1'b1;
                end
            end else if (done_vld && done_rdy) begin
                done_vld <= 1'b0;
            end
        end
    end

endmodule

// File: doc/count_limit_checker.md
Name: count_limit_checker

Overview:
- Downstream monitor for a small saturating up-counter (a 0..LIMIT counter).
- Samples the counter value on a strobe and tracks progress from 0 to LIMIT with an FSM.
- Reports each completed climb over a valid/ready handshake.
- Latches a sticky error on any illegal value (above LIMIT) or non-monotonic step, so a counter that escapes its legal range is flagged.

Parameters:
W, 3, width of the sampled counter value
LIMIT, 3, terminal (maximum legal) count; must satisfy 1 <= LIMIT <= 2^W-1
SW, 4, width of the done_samples payload counter

Ports:
clk  in  1  clock, rising edge
resetn  in  1  synchronous reset, active-low
cnt_in  in  W  counter value from upstream
cnt_vld  in  1  cnt_in is sampled on a rising edge only when this is 1
done_vld  out  1  completion payload valid
done_rdy  in  1  consumer accepts payload when done_vld & done_rdy at a rising edge
done_samples  out  SW  samples taken from leaving 0 up to and including the LIMIT sample
done_ovr  out  1  sticky: a completion was dropped while done_vld was pending
err  out  1  sticky illegal-behaviour flag
err_val  out  W  first offending cnt_in value
state  out  2  FSM state: IDLE=0, RUN=1, HOLD=2, ERR=3

Behaviour:
- Reset: clk is the clock; resetn is a synchronous, active-low reset. While resetn=0 at a rising edge:
  - state=IDLE; done_vld=0; done_samples=0; done_ovr=0; err=0; err_val=0.
  - The internal sample counter and last-value register are cleared to 0.
  - Reset mid-operation drops any pending payload.
- Sampling: nothing changes on edges with cnt_vld=0, except the done handshake.
- Illegal value: cnt_in > LIMIT in any non-ERR state -> ERR, err=1, err_val=cnt_in. This has priority over every other transition.
- IDLE:
  - sample 0 -> stay.
  - sample 1..LIMIT-1 -> RUN, scnt=1, last=cnt_in.
  - sample ==LIMIT -> HOLD, completion with samples=1.
- RUN:
  - sample < last and sample != 0 -> ERR (err_val=cnt_in).
  - sample 0 -> IDLE, no completion.
  - sample ==LIMIT -> HOLD, completion with samples=scnt+1 (saturating).
  - otherwise stay, scnt=scnt+1 saturating at 2^SW-1, last=cnt_in.
- HOLD:
  - sample ==LIMIT -> stay.
  - sample 0 -> IDLE.
  - sample 1..LIMIT-1 -> ERR (counter left its saturation point without reset).
- ERR: absorbing; only resetn exits (see optional feature). err and err_val stay stable.
- Completion:
  - If done_vld=0, or done_vld=1 with done_rdy=1 on the same edge: done_vld<=1, done_samples<=new count.
  - Otherwise the completion is dropped, done_ovr<=1, and the payload is unchanged.
- Handshake:
  - done_vld & done_rdy at an edge with no new completion -> done_vld<=0 next cycle.
  - done_samples is stable while done_vld=1 and not accepted.
  - A pending payload survives transitions to IDLE or ERR.
- Latency: one cycle from sampling edge to state, done_vld and err update. Outputs are registered; no combinational path from inputs to outputs.
- LIMIT=1 is legal: IDLE goes directly to HOLD on sample 1.

Optional Feature:
- Macro: COUNT_LIMIT_ERR_CLR_EN.
- When defined:
  - Adds input port err_clr (1 bit).
  - err_clr=1 at an edge while state=ERR -> state=IDLE, err=0, err_val=0, scnt=0, last=0.
  - done_vld, done_samples and done_ovr are unaffected.
  - Ignored in other states; resetn has priority.
- When undefined: port absent; ERR exits only via resetn.

Test Plan:
- Reset, then cnt_vld=1 with cnt_in 0,1,2,3 on consecutive edges, done_rdy=0 -> state 0,1,1,2; done_vld=1 with done_samples=3; hold done_rdy=0 for 5 cycles -> payload stable; done_rdy=1 -> done_vld=0 the next cycle.
- cnt_in 1,1,2,2,3 -> done_samples=5.
- cnt_in 0, then 4 -> state=3, err=1, err_val=4. Then cnt_in 0 -> still ERR. resetn=0 for one edge -> all outputs 0.
- cnt_in 1,2,1 -> ERR with err_val=1.
- HOLD, then cnt_in 2 -> ERR with err_val=2.
- Two full climbs 0,1,2,3,0,1,2,3 with done_rdy=0 -> first payload done_samples=3 kept; done_ovr=1.
- Climb with done_rdy=1 on the edge the second completion arrives -> new payload loaded, done_ovr=0.
- cnt_vld=0 for 10 cycles with cnt_in toggling 0..7 -> no state change.
- With COUNT_LIMIT_ERR_CLR_EN defined: force ERR via cnt_in=5, pulse err_clr -> state=0, err=0; next climb 1,2,3 completes with done_samples=3.
